axi_lite_read_responder: RTL and testbench
==========================================

# axi_lite_read_responder

AXI4-Lite read-side slave that terminates the read address and read data channels for a bank of 32-bit status/control registers. It accepts one AR beat per cycle, decodes it to a register index, and returns the registered word with a response code on the R channel. It is the responder counterpart to the peripheral-facing AXI-Lite read master ports. It also pulses a per-register read strobe so owners can implement clear-on-read bits.

## Interface
- AXI_ARADDR_WIDTH, 8: byte address width on AR.
- AXI_DATA_WIDTH, 32: R data width; fixed at 32, other values unsupported.
- NUM_REGS, 16: number of word registers; 1..2^(AXI_ARADDR_WIDTH-2).
- SECURE_MASK, '0 (NUM_REGS bits): bit i set means register i is secure-only.

Ports:
- aclk  in  1  sole clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- arvalid  in  1  AR valid.
- arready  out  1  AR ready.
- araddr  in  AXI_ARADDR_WIDTH  byte address.
- arprot  in  3  protection; only arprot[1] (non-secure) is used.
- rvalid  out  1  R valid.
- rready  in  1  R ready.
- rdata  out  AXI_DATA_WIDTH  read data.
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- reg_rdata  in  NUM_REGS*32  flattened register values; register i occupies [32*i+31:32*i].
- rd_pulse  out  NUM_REGS  one-cycle strobe per successful read of register i.

## Operation
- Index is araddr[AXI_ARADDR_WIDTH-1:2]. araddr[1:0] are ignored, so unaligned reads return the containing word.
- The AR handshake occurs in any cycle with arvalid && arready.
- Response selection at handshake:
  - index >= NUM_REGS: SLVERR, rdata = 0.
  - SECURE_MASK[index] && arprot[1]: SLVERR, rdata = 0.
  - Otherwise: OKAY, rdata = reg_rdata word[index], sampled in the handshake cycle.
- rd_pulse[index] is set only for OKAY responses, never for SLVERR.
- Two states:
  - IDLE (rvalid=0): an AR handshake moves to RESP.
  - RESP (rvalid=1):
    - rready && no new handshake: go to IDLE.
    - rready && new handshake in the same cycle: stay in RESP and load the new response.
    - !rready: hold.
- arready = aresetn && (!rvalid || rready). At most one response is outstanding, with no extra buffering.
- While rvalid && !rready, rdata and rresp are stable. A change in reg_rdata does not alter a pending response.

## Timing
- Reset, sampled on aclk while aresetn=0:
  - rvalid=0, rdata=0, rresp=2'b00, rd_pulse=0, state IDLE.
  - arready is forced 0 while aresetn=0.
- First cycle after aresetn rises: arready=1.
- Latency: handshake at edge N gives rvalid=1 with rdata/rresp valid from edge N+1.
- rd_pulse is asserted after edge N+1 for exactly one cycle, coincident with rvalid rising or reloading. It does not depend on rready.
- Throughput: one read per cycle while rready is held 1, with back-to-back handshakes.
- R-channel stall: arready drops combinationally, and AR is not accepted until the R handshake.
- Reset mid-transaction: the pending response is discarded. rvalid=0 and rd_pulse=0 after the reset edge, and no R beat is issued for it.
- rready=1 in IDLE has no effect.

## Test plan
- Reset then idle: hold aresetn=0 for 3 cycles with arvalid=0.
  - Required: rvalid=0, rd_pulse=0, arready=0 during reset; arready=1 one cycle after release.
- Single OKAY read: reg 3 = 0xDEADBEEF, araddr=0x0E, arprot=0, rready=1.
  - Required: next cycle rvalid=1, rdata=0xDEADBEEF, rresp=00, rd_pulse=16'h0008 for one cycle, then rvalid=0.
- Decode error: araddr=0x40 with NUM_REGS=16.
  - Required: rresp=10, rdata=0, rd_pulse=0.
- Secure violation: SECURE_MASK bit 5 set, araddr=0x14.
  - arprot=3'b010: rresp=10, no rd_pulse.
  - arprot=3'b000: rresp=00 with the reg 5 data.
- Backpressure: rready=0 for 4 cycles after the handshake while reg_rdata changes and arvalid stays 1.
  - Required: arready=0, rdata stable throughout.
  - rready=1: the R beat completes and the next AR is accepted in the same cycle; its data appears next cycle.
- Streaming: 8 consecutive reads, indices 0..7, with rready=1.
  - Required: 8 R beats on consecutive cycles, in order, with correct data and 8 single-cycle rd_pulse bits.

Source files
------------

// File: rtl/axi_lite_read_responder.sv
// AXI4-Lite read responder for a bank of 32-bit registers: one outstanding R beat,
// decode/secure errors answered with SLVERR, per-register read strobe for clear-on-read owners.
module axi_lite_read_responder #(
   parameter int                  AXI_ARADDR_WIDTH = 8,
   parameter int                  AXI_DATA_WIDTH   = 32,
   parameter int                  NUM_REGS         = 16,
   parameter logic [NUM_REGS-1:0] SECURE_MASK      = '0
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        arvalid,
   output logic                        arready,
   input  logic [AXI_ARADDR_WIDTH-1:0] araddr,
   input  logic [2:0]                  arprot,
   output logic                        rvalid,
   input  logic                        rready,
   output logic [AXI_DATA_WIDTH-1:0]   rdata,
   output logic [1:0]                  rresp,
   input  logic [NUM_REGS*32-1:0]      reg_rdata,
   output logic [NUM_REGS-1:0]         rd_pulse,
   output logic                        dbg_state
);

   localparam int                 IDX_W      = AXI_ARADDR_WIDTH - 2;
   localparam logic [IDX_W:0]     NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
   localparam logic [1:0]         RESP_OKAY  = 2'b00;
   localparam logic [1:0]         RESP_SLV   = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t                      state;
   state_t                      state_nxt;
   logic                        ar_hs;
   logic [IDX_W-1:0]            idx;
   logic                        idx_ok;
   logic                        sec_bit;
   logic                        resp_ok;
   logic [AXI_DATA_WIDTH-1:0]   word_sel;
   logic [NUM_REGS-1:0]         pulse_nxt;
   logic [AXI_DATA_WIDTH-1:0]   rdata_q;
   logic [1:0]                  rresp_q;
   logic [NUM_REGS-1:0]         rd_pulse_q;
   logic                        unused_addr_bits;

   // Valid/ready: a beat transfers on any rising edge where valid && ready are both high;
   // rvalid/rdata/rresp stay frozen until the R beat transfers, and a new AR is taken
   // only when the R slot is empty or being emptied in the same cycle.
   assign rvalid  = (state == RESP);
   assign arready = aresetn && (!rvalid || rready);
   assign ar_hs   = arvalid && arready;

   assign idx     = araddr[AXI_ARADDR_WIDTH-1:2];
   assign idx_ok  = ({1'b0, idx} < NUM_REGS_W);
   assign resp_ok = idx_ok && !(sec_bit && arprot[1]);

   assign unused_addr_bits = ^{araddr[1:0], arprot[2], arprot[0]};

   // Mux out the addressed word and its secure bit; out-of-range indices select nothing.
   always_comb begin
      word_sel  = '0;
      sec_bit   = 1'b0;
      pulse_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == IDX_W'(i)) begin
            word_sel     = reg_rdata[32*i +: 32];
            sec_bit      = SECURE_MASK[i];
            pulse_nxt[i] = ar_hs && resp_ok;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ar_hs) state_nxt = RESP;
         RESP:    if (rready && !ar_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state      <= IDLE;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         rd_pulse_q <= '0;
      end else begin
         state      <= state_nxt;
         rd_pulse_q <= pulse_nxt;
         if (ar_hs) begin
            rdata_q <= resp_ok ? word_sel : '0;
            rresp_q <= resp_ok ? RESP_OKAY : RESP_SLV;
         end
      end
   end

   assign rdata     = rdata_q;
   assign rresp     = rresp_q;
   assign rd_pulse  = rd_pulse_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_axi_lite_read_responder.sv
// Bench for axi_lite_read_responder: directed scenarios plus a randomized run scored
// against a transaction-level model of the read responder.
module tb_axi_lite_read_responder;

   localparam int             AW    = 8;
   localparam int             DW    = 32;
   localparam int             NR    = 16;
   localparam logic [NR-1:0]  SMASK = 16'h8020;
   localparam int             EW    = 2 + DW + NR;

   logic               aclk      = 1'b0;
   logic               aresetn   = 1'b0;
   logic               arvalid   = 1'b0;
   logic               arready;
   logic [AW-1:0]      araddr    = '0;
   logic [2:0]         arprot    = '0;
   logic               rvalid;
   logic               rready    = 1'b0;
   logic [DW-1:0]      rdata;
   logic [1:0]         rresp;
   logic [NR*32-1:0]   reg_rdata = '0;
   logic [NR-1:0]      rd_pulse;
   logic               dbg_state;

   int checks   = 0;
   int failures = 0;

   // Expected response entries: {rresp, rdata, rd_pulse}
   logic [EW-1:0] exp_q[$];

   always #5 aclk = ~aclk;

   axi_lite_read_responder #(
      .AXI_ARADDR_WIDTH(AW),
      .AXI_DATA_WIDTH  (DW),
      .NUM_REGS        (NR),
      .SECURE_MASK     (SMASK)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .arvalid   (arvalid),
      .arready   (arready),
      .araddr    (araddr),
      .arprot    (arprot),
      .rvalid    (rvalid),
      .rready    (rready),
      .rdata     (rdata),
      .rresp     (rresp),
      .reg_rdata (reg_rdata),
      .rd_pulse  (rd_pulse),
      .dbg_state (dbg_state)
   );

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // What a read of addr with prot should return, given the register snapshot.
   function automatic logic [EW-1:0] ref_resp(input logic [AW-1:0] addr, input logic [2:0] prot,
                                              input logic [NR*32-1:0] regs);
      int idx;
      logic [NR-1:0] one;
      idx = int'(addr) / 4;
      if (idx >= NR) return {2'b10, {DW{1'b0}}, {NR{1'b0}}};
      if (SMASK[idx] && prot[1]) return {2'b10, {DW{1'b0}}, {NR{1'b0}}};
      one = '0;
      one[idx] = 1'b1;
      return {2'b00, regs[idx*32 +: 32], one};
   endfunction

   task automatic test_reset();
      aresetn = 1'b0;
      arvalid = 1'b0;
      rready  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid cyc=%0d got=%b exp=0", c, rvalid); end
         checks++; if (rd_pulse !== '0) begin failures++; $display("FAIL reset_rd_pulse cyc=%0d got=%h exp=0", c, rd_pulse); end
         checks++; if (arready !== 1'b0) begin failures++; $display("FAIL reset_arready cyc=%0d got=%b exp=0", c, arready); end
         checks++; if (rdata !== '0 || rresp !== 2'b00) begin failures++; $display("FAIL reset_rdata got=%h/%b exp=0/00", rdata, rresp); end
         checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
      end
      tick();
      aresetn = 1'b1;
      tick();
      @(negedge aclk);
      checks++; if (arready !== 1'b1) begin failures++; $display("FAIL post_reset_arready got=%b exp=1", arready); end
      checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL post_reset_rvalid got=%b exp=0", rvalid); end
   endtask

   task automatic test_single_okay();
      tick();
      reg_rdata[3*32 +: 32] = 32'hDEADBEEF;
      arvalid = 1'b1; araddr = 8'h0E; arprot = 3'b000; rready = 1'b1;
      @(negedge aclk);
      checks++; if (arready !== 1'b1) begin failures++; $display("FAIL single_arready got=%b exp=1", arready); end
      tick();
      arvalid = 1'b0;
      @(negedge aclk);
      checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL single_rvalid got=%b exp=1", rvalid); end
      checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata); end
      checks++; if (rresp !== 2'b00) begin failures++; $display("FAIL single_rresp got=%b exp=00", rresp); end
      checks++; if (rd_pulse !== 16'h0008) begin failures++; $display("FAIL single_rd_pulse got=%h exp=0008", rd_pulse); end
      tick();
      @(negedge aclk);
      checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL single_rvalid_drop got=%b exp=0", rvalid); end
      checks++; if (rd_pulse !== '0) begin failures++; $display("FAIL single_pulse_drop got=%h exp=0", rd_pulse); end
   endtask

   task automatic test_decode_error();
      tick();
      arvalid = 1'b1; araddr = 8'h40; arprot = 3'b000; rready = 1'b1;
      tick();
      arvalid = 1'b0;
      @(negedge aclk);
      checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL decerr_rvalid got=%b exp=1", rvalid); end
      checks++; if (rresp !== 2'b10) begin failures++; $display("FAIL decerr_rresp got=%b exp=10", rresp); end
      checks++; if (rdata !== '0) begin failures++; $display("FAIL decerr_rdata got=%h exp=0", rdata); end
      checks++; if (rd_pulse !== '0) begin failures++; $display("FAIL decerr_rd_pulse got=%h exp=0", rd_pulse); end
   endtask

   task automatic test_secure();
      logic [31:0] w5;
      w5 = $urandom();
      tick();
      reg_rdata[5*32 +: 32] = w5;
      arvalid = 1'b1; araddr = 8'h14; arprot = 3'b010; rready = 1'b1;
      tick();
      arprot = 3'b000;
      @(negedge aclk);
      checks++; if (rresp !== 2'b10 || rdata !== '0) begin failures++; $display("FAIL secure_ns got=%b/%h exp=10/0", rresp, rdata); end
      checks++; if (rd_pulse !== '0) begin failures++; $display("FAIL secure_ns_pulse got=%h exp=0", rd_pulse); end
      tick();
      arvalid = 1'b0;
      @(negedge aclk);
      checks++; if (rvalid !== 1'b1 || rresp !== 2'b00) begin failures++; $display("FAIL secure_s_resp got=%b/%b exp=1/00", rvalid, rresp); end
      checks++; if (rdata !== w5) begin failures++; $display("FAIL secure_s_rdata got=%h exp=%h", rdata, w5); end
      checks++; if (rd_pulse !== 16'h0020) begin failures++; $display("FAIL secure_s_pulse got=%h exp=0020", rd_pulse); end
   endtask

   task automatic test_backpressure();
      logic [31:0] wa;
      logic [31:0] wb;
      wa = $urandom();
      tick();
      rready = 1'b0;
      reg_rdata[2*32 +: 32] = wa;
      arvalid = 1'b1; araddr = 8'h08; arprot = 3'b000;
      tick();
      araddr = 8'h10;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         for (int r = 0; r < NR; r++) reg_rdata[r*32 +: 32] = $urandom();
         @(negedge aclk);
         checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL bp_rvalid k=%0d got=%b exp=1", k, rvalid); end
         checks++; if (arready !== 1'b0) begin failures++; $display("FAIL bp_arready k=%0d got=%b exp=0", k, arready); end
         checks++; if (rdata !== wa || rresp !== 2'b00) begin failures++; $display("FAIL bp_rdata k=%0d got=%h exp=%h", k, rdata, wa); end
         checks++; if (rd_pulse !== ((k == 0) ? 16'h0004 : 16'h0000)) begin failures++; $display("FAIL bp_pulse k=%0d got=%h", k, rd_pulse); end
      end
      tick();
      rready = 1'b1;
      wb = reg_rdata[4*32 +: 32];
      @(negedge aclk);
      checks++; if (arready !== 1'b1) begin failures++; $display("FAIL bp_release_arready got=%b exp=1", arready); end
      tick();
      arvalid = 1'b0;
      @(negedge aclk);
      checks++; if (rvalid !== 1'b1 || rdata !== wb) begin failures++; $display("FAIL bp_next_rdata got=%b/%h exp=1/%h", rvalid, rdata, wb); end
      checks++; if (rd_pulse !== 16'h0010) begin failures++; $display("FAIL bp_next_pulse got=%h exp=0010", rd_pulse); end
      tick();
      @(negedge aclk);
      checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", rvalid); end
   endtask

   task automatic test_streaming();
      logic [NR*32-1:0] snap;
      logic [NR-1:0]    one;
      tick();
      for (int r = 0; r < NR; r++) reg_rdata[r*32 +: 32] = $urandom();
      snap = reg_rdata;
      rready = 1'b1; arprot = 3'b000;
      for (int k = 0; k <= 8; k++) begin
         if (k < 8) begin arvalid = 1'b1; araddr = AW'(k * 4); end
         else arvalid = 1'b0;
         @(negedge aclk);
         if (k > 0) begin
            one = '0;
            one[k-1] = 1'b1;
            checks++; if (rvalid !== 1'b1 || rdata !== snap[(k-1)*32 +: 32] || rresp !== 2'b00) begin
               failures++; $display("FAIL stream_beat%0d got=%b/%h/%b exp=1/%h/00", k - 1, rvalid, rdata, rresp, snap[(k-1)*32 +: 32]);
            end
            checks++; if (rd_pulse !== one) begin failures++; $display("FAIL stream_pulse%0d got=%h exp=%h", k - 1, rd_pulse, one); end
         end
         if (k < 8) begin
            checks++; if (arready !== 1'b1) begin failures++; $display("FAIL stream_arready%0d got=%b exp=1", k, arready); end
         end
         tick();
      end
      @(negedge aclk);
      checks++; if (rvalid !== 1'b0 || rd_pulse !== '0) begin failures++; $display("FAIL stream_end got=%b/%h exp=0/0", rvalid, rd_pulse); end
   endtask

   task automatic test_reset_mid();
      tick();
      rready = 1'b0;
      arvalid = 1'b1; araddr = 8'h0C; arprot = 3'b000;
      tick();
      arvalid = 1'b0;
      @(negedge aclk);
      checks++; if (rvalid !== 1'b1) begin failures++; $display("FAIL rstmid_pending got=%b exp=1", rvalid); end
      tick();
      aresetn = 1'b0;
      @(negedge aclk);
      checks++; if (arready !== 1'b0) begin failures++; $display("FAIL rstmid_arready got=%b exp=0", arready); end
      tick();
      aresetn = 1'b1;
      rready  = 1'b1;
      @(negedge aclk);
      checks++; if (rvalid !== 1'b0 || rd_pulse !== '0) begin failures++; $display("FAIL rstmid_cleared got=%b/%h exp=0/0", rvalid, rd_pulse); end
      tick();
      @(negedge aclk);
      checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_no_beat got=%b exp=0", rvalid); end
   endtask

   task automatic test_random();
      logic [NR-1:0] pulse_exp;
      logic [EW-1:0] e;
      logic          exp_rvalid;
      logic          exp_arready;
      int            wi;
      pulse_exp = '0;
      exp_q.delete();
      tick();
      for (int n = 0; n < 400; n++) begin
         arvalid = ($urandom_range(0, 3) != 0);
         araddr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 63));
         arprot  = 3'($urandom_range(0, 7));
         rready  = ($urandom_range(0, 3) != 0);
         wi = $urandom_range(0, NR - 1);
         reg_rdata[wi*32 +: 32] = $urandom();
         @(negedge aclk);
         exp_rvalid  = (exp_q.size() != 0);
         exp_arready = !exp_rvalid || rready;
         checks++; if (rvalid !== exp_rvalid) begin failures++; $display("FAIL rand_rvalid n=%0d got=%b exp=%b", n, rvalid, exp_rvalid); end
         checks++; if (arready !== exp_arready) begin failures++; $display("FAIL rand_arready n=%0d got=%b exp=%b", n, arready, exp_arready); end
         checks++; if (rd_pulse !== pulse_exp) begin failures++; $display("FAIL rand_pulse n=%0d got=%h exp=%h", n, rd_pulse, pulse_exp); end
         if (exp_rvalid) begin
            checks++; if (rresp !== exp_q[0][EW-1 -: 2] || rdata !== exp_q[0][NR +: DW]) begin
               failures++; $display("FAIL rand_beat n=%0d got=%b/%h exp=%b/%h", n, rresp, rdata, exp_q[0][EW-1 -: 2], exp_q[0][NR +: DW]);
            end
         end
         pulse_exp = '0;
         if (exp_rvalid && rready) void'(exp_q.pop_front());
         if (arvalid && exp_arready) begin
            e = ref_resp(araddr, arprot, reg_rdata);
            exp_q.push_back(e);
            pulse_exp = e[NR-1:0];
         end
         tick();
      end
      arvalid = 1'b0;
      rready  = 1'b1;
      tick();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_single_okay();
      test_decode_error();
      test_secure();
      test_backpressure();
      test_streaming();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
